// File: rtl/map_cfg_seq_pkg.sv
// ---------------------------------------------------------------------------
// map_cfg_seq_pkg
// Shared mapper definitions: the reconfiguration FSM state enum, the
// mapper-core selection codes driven into the hub, and the configuration
// byte bundle used to describe the active/shadow register set.
// ---------------------------------------------------------------------------
package map_cfg_seq_pkg;

    // Reconfiguration sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_APPLY  = 2'd2,
        ST_SETTLE = 2'd3
    } seq_state_t;

    // Mapper-core selection codes (hub steering)
    localparam logic [3:0] CORE_NOM = 4'd0;  // nominal core, any unlisted index
    localparam logic [3:0] CORE_C1  = 4'd1;  // 79, 113, 146
    localparam logic [3:0] CORE_C2  = 4'd2;  // 90, 209, 211
    localparam logic [3:0] CORE_C3  = 4'd3;  // 133
    localparam logic [3:0] CORE_C4  = 4'd4;  // 137, 138, 139, 141
    localparam logic [3:0] CORE_C5  = 4'd5;  // 147
    localparam logic [3:0] CORE_C6  = 4'd6;  // 148
    localparam logic [3:0] CORE_C7  = 4'd7;  // 150, 243

    // Shadow register indices
    localparam logic [1:0] CFG_MAP_IDX = 2'd0;
    localparam logic [1:0] CFG_PRG_MSK = 2'd1;
    localparam logic [1:0] CFG_CHR_MSK = 2'd2;
    localparam logic [1:0] CFG_FLAGS   = 2'd3;

    // Mapper configuration as seen by the cores
    typedef struct packed {
        logic [7:0] map_idx;
        logic [7:0] prg_msk;
        logic [7:0] chr_msk;
        logic [7:0] flags;
    } map_cfg_t;

endpackage

// File: rtl/map_core_dec.sv
// ---------------------------------------------------------------------------
// map_core_dec
// Combinational decode of a mapper index into a mapper-core selection code.
// Ports:
//   i_map_idx  [7:0]  mapper index
//   o_core_sel [3:0]  core selection code (CORE_* in map_cfg_seq_pkg)
// ---------------------------------------------------------------------------
module map_core_dec
    import map_cfg_seq_pkg::*;
(
    input  logic [7:0] i_map_idx,
    output logic [3:0] o_core_sel
);

    always_comb begin
        o_core_sel = CORE_NOM;
        case (i_map_idx)
            8'd79,  8'd113, 8'd146:          o_core_sel = CORE_C1;
            8'd90,  8'd209, 8'd211:          o_core_sel = CORE_C2;
            8'd133:                          o_core_sel = CORE_C3;
            8'd137, 8'd138, 8'd139, 8'd141:  o_core_sel = CORE_C4;
            8'd147:                          o_core_sel = CORE_C5;
            8'd148:                          o_core_sel = CORE_C6;
            8'd150, 8'd243:                  o_core_sel = CORE_C7;
            default:                         o_core_sel = CORE_NOM;
        endcase
    end

endmodule

// File: rtl/map_cfg_seq.sv
// ---------------------------------------------------------------------------
// map_cfg_seq
// Mapper reconfiguration sequencer. Configuration bytes are written into a
// shadow set while idle; a commit holds the mapper cores in reset, swaps
// shadow into active, lets the cores settle, then releases reset.
// Ports:
//   clk, rst (async, active high)
//   cfg_we, cfg_addr[1:0], cfg_di[7:0]  shadow byte write (idle only)
//   commit                              request shadow-to-active swap
//   map_idx, prg_msk, chr_msk, flags    active configuration bytes
//   core_sel[3:0]                       registered mapper-core selection
//   map_rst                             reset to mapper cores
//   busy, done, err                     sequencer status
// ---------------------------------------------------------------------------
module map_cfg_seq
    import map_cfg_seq_pkg::*;
#(
    parameter int RST_CYC    = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_di,
    input  logic       commit,
    output logic [7:0] map_idx,
    output logic [7:0] prg_msk,
    output logic [7:0] chr_msk,
    output logic [7:0] flags,
    output logic [3:0] core_sel,
    output logic       map_rst,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] RST_LOAD    = 8'(RST_CYC - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    seq_state_t r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_shadow [4];
    logic [7:0] r_active [4];
    logic [3:0] r_core_sel;
    logic       r_map_rst;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic [3:0] w_core_sel;

    // Decode from the shadow index so the registered code lands together
    // with the bytes it describes.
    map_core_dec u_core_dec (
        .i_map_idx  (r_shadow[CFG_MAP_IDX]),
        .o_core_sel (w_core_sel)
    );

    // Shadow bytes accept writes only while idle; a write issued together
    // with a commit lands on the same edge, long before APPLY reads it.
    for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_shadow[gi] <= 8'h00;
            end else if (cfg_we && (r_state == ST_IDLE) && (cfg_addr == 2'(gi))) begin
                r_shadow[gi] <= cfg_di;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_core_sel <= CORE_NOM;
            r_map_rst  <= 1'b1;   // cores stay in reset until the first commit completes
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_active[i] <= 8'h00;
            end
        end else begin
            r_done <= 1'b0;

            // Anything arriving while the sequence runs is dropped and flagged
            if ((r_state != ST_IDLE) && (cfg_we || commit)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (commit) begin
                        r_state   <= ST_HOLD;
                        r_cnt     <= RST_LOAD;
                        r_map_rst <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_APPLY;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_APPLY: begin
                    for (int i = 0; i < 4; i++) begin
                        r_active[i] <= r_shadow[i];
                    end
                    r_core_sel <= w_core_sel;
                    r_cnt      <= SETTLE_LOAD;
                    r_state    <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        r_state   <= ST_IDLE;
                        r_map_rst <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign map_idx  = r_active[CFG_MAP_IDX];
    assign prg_msk  = r_active[CFG_PRG_MSK];
    assign chr_msk  = r_active[CFG_CHR_MSK];
    assign flags    = r_active[CFG_FLAGS];
    assign core_sel = r_core_sel;
    assign map_rst  = r_map_rst;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_map_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_map_cfg_seq
// Directed bench for map_cfg_seq with default parameters. Each commit pushes
// its expected applied configuration and done cycle into a queue; a monitor
// pops one entry per done pulse and compares.
// ---------------------------------------------------------------------------
module tb_map_cfg_seq;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_di;
    logic       commit;
    logic [7:0] map_idx;
    logic [7:0] prg_msk;
    logic [7:0] chr_msk;
    logic [7:0] flags;
    logic [3:0] core_sel;
    logic       map_rst;
    logic       busy;
    logic       done;
    logic       err;

    map_cfg_seq dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_di   (cfg_di),
        .commit   (commit),
        .map_idx  (map_idx),
        .prg_msk  (prg_msk),
        .chr_msk  (chr_msk),
        .flags    (flags),
        .core_sel (core_sel),
        .map_rst  (map_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of rising edges; an event sampled at edge N is seen at negedge with cyc==N
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [7:0] mi;
        logic [7:0] pm;
        logic [7:0] cm;
        logic [7:0] fl;
        logic [3:0] cs;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors = vectors + 1;
        if (act !== req) begin
            miscompares = miscompares + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s = 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding commit
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                chk("done_map_idx", 32'(map_idx), 32'(e.mi));
                chk("done_prg_msk", 32'(prg_msk), 32'(e.pm));
                chk("done_chr_msk", 32'(chr_msk), 32'(e.cm));
                chk("done_flags", 32'(flags), 32'(e.fl));
                chk("done_core_sel", 32'(core_sel), 32'(e.cs));
                chk("done_map_rst", 32'(map_rst), 32'h0);
                chk("done_busy", 32'(busy), 32'h0);
            end
        end
    end

    task automatic write_cfg(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_di = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Commit (optionally with a same-cycle write); returns the sampling edge number
    task automatic do_commit(input logic [7:0] mi, input logic [7:0] pm, input logic [7:0] cm,
                             input logic [7:0] fl, input logic [3:0] cs, input logic push,
                             input logic we, input logic [1:0] a, input logic [7:0] d,
                             output int k);
        exp_t e;
        k = cyc + 1;
        e.mi = mi; e.pm = pm; e.cm = cm; e.fl = fl; e.cs = cs; e.done_cyc = k + 21;
        if (push) sb.push_back(e);
        commit = 1'b1; cfg_we = we; cfg_addr = a; cfg_di = d;
        @(negedge clk);
        commit = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'h0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_map_idx"}, 32'(map_idx), 32'h0);
        chk({tag, "_prg_msk"}, 32'(prg_msk), 32'h0);
        chk({tag, "_chr_msk"}, 32'(chr_msk), 32'h0);
        chk({tag, "_flags"}, 32'(flags), 32'h0);
        chk({tag, "_core_sel"}, 32'(core_sel), 32'h0);
        chk({tag, "_map_rst"}, 32'(map_rst), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_di = 8'h00; commit = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state("post_rst");

        // Basic swap: index 90 -> core 2
        write_cfg(2'd0, 8'h5A);
        write_cfg(2'd1, 8'h1F);
        do_commit(8'h5A, 8'h1F, 8'h00, 8'h00, 4'd2, 1'b1, 1'b0, 2'd0, 8'h00, k);
        wait_cyc(k + 1);
        chk("s1_busy", 32'(busy), 32'h1);
        chk("s1_map_rst_hold", 32'(map_rst), 32'h1);
        wait_cyc(k + 16);
        chk("s1_map_idx_pre_apply", 32'(map_idx), 32'h0);
        wait_cyc(k + 17);
        chk("s1_map_idx_apply", 32'(map_idx), 32'h5A);
        chk("s1_prg_msk_apply", 32'(prg_msk), 32'h1F);
        chk("s1_core_sel_apply", 32'(core_sel), 32'h2);
        chk("s1_map_rst_settle", 32'(map_rst), 32'h1);
        wait_cyc(k + 20);
        chk("s1_done_not_early", 32'(done), 32'h0);
        wait_idle();
        chk("s1_err", 32'(err), 32'h0);

        // Nominal core
        write_cfg(2'd0, 8'h05);
        do_commit(8'h05, 8'h1F, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 2'd0, 8'h00, k);
        wait_idle();

        // Write during HOLD is dropped and flags err
        do_commit(8'h05, 8'h1F, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 2'd0, 8'h00, k);
        wait_cyc(k + 3);
        chk("s3_err_before", 32'(err), 32'h0);
        write_cfg(2'd0, 8'h90);
        chk("s3_err_after", 32'(err), 32'h1);
        wait_idle();
        chk("s3_map_idx_kept", 32'(map_idx), 32'h05);

        // Reset in the middle of HOLD: abort, no done, no partial apply
        write_cfg(2'd2, 8'hC3);
        do_commit(8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 2'd0, 8'h00, k);
        wait_cyc(k + 5);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk_reset_state("midrst_after");

        // Fresh commit after abort; a second commit in SETTLE is dropped
        write_cfg(2'd0, 8'h8A);
        do_commit(8'h8A, 8'h00, 8'h00, 8'h00, 4'd4, 1'b1, 1'b0, 2'd0, 8'h00, k);
        wait_cyc(k + 19);
        chk("s5_err_before", 32'(err), 32'h0);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        chk("s5_err_after", 32'(err), 32'h1);
        wait_idle();
        repeat (25) @(negedge clk);
        chk("s5_no_restart_busy", 32'(busy), 32'h0);
        chk("s5_no_restart_map_rst", 32'(map_rst), 32'h0);

        // Same-cycle write and commit: the new byte is part of the swap
        write_cfg(2'd2, 8'h42);
        write_cfg(2'd3, 8'h81);
        do_commit(8'hF3, 8'h00, 8'h42, 8'h81, 4'd7, 1'b1, 1'b1, 2'd0, 8'hF3, k);
        wait_idle();
        chk("s6_map_idx", 32'(map_idx), 32'hF3);
        chk("s6_core_sel", 32'(core_sel), 32'h7);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
